dm_ctrl: RTL
============

Name: dm_ctrl

Overview:
- Initiator-side controller for the data memory `dm`.
- Accepts single-word store requests and burst load requests from the pipeline over a valid/ready request channel.
- Sequences `dm`'s we/D/addr/Q port and returns one response beat per stored or loaded word over a valid/ready response channel.
- Sits between the MEM stage and `dm`. It is the only driver of `dm`'s input ports.

Parameters:
- DATA_WIDTH, 16, word width; matches `dm`.
- DM_ADDRESS_WIDTH, 6, word address width; matches `dm`.
- DM_DEPTH, 64, number of implemented words; must be <= 2**DM_ADDRESS_WIDTH.
- LEN_WIDTH, 2, burst length field width; beats = req_len+1, so 1..4 beats.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  DM_ADDRESS_WIDTH  start word address.
- req_wdata  input  DATA_WIDTH  store data.
- req_len  input  LEN_WIDTH  load beats minus 1; ignored for stores.
- resp_valid  output  1  response beat present.
- resp_ready  input  1  consumer accepts beat.
- resp_rdata  output  DATA_WIDTH  load data; 0 for store acks and errors.
- resp_err  output  1  out-of-range request.
- resp_last  output  1  final beat of the transaction.
- dm_we  output  1  to `dm` we.
- dm_addr  output  DM_ADDRESS_WIDTH  to `dm` addr.
- dm_d  output  DATA_WIDTH  to `dm` D.
- dm_q  input  DATA_WIDTH  from `dm` Q.

Behaviour:
- Memory contract with `dm`:
  - Write occurs on the rising edge where dm_we=1.
  - Q reflects the word at the addr sampled on an edge, valid the following cycle (synchronous read).
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - req_ready, dm_we, resp_valid, resp_err, resp_last = 0.
  - dm_addr, dm_d, resp_rdata = 0.
  - Any burst in flight is aborted: no further dm_we and no response for it.
  - req_ready is 1 from the first cycle after rst deasserts.
- State machine: IDLE, WR, RD_ADDR, RD_CAP, RESP. All outputs are registered.
- IDLE:
  - req_ready=1.
  - On handshake (req_valid & req_ready) latch we, addr, wdata, len into the addr/data/beat-counter registers.
  - If req_addr >= DM_DEPTH: go to RESP with err=1, last=1, rdata=0. No `dm` access, for stores and loads alike.
  - Otherwise: store goes to WR; load goes to RD_ADDR.
- WR:
  - dm_we=1, dm_addr=latched addr, dm_d=latched wdata for exactly one cycle.
  - Next state is RESP with err=0, last=1, rdata=0.
- RD_ADDR: dm_addr=current beat addr, dm_we=0. Next state is RD_CAP.
- RD_CAP: capture dm_q into resp_rdata. Next state is RESP, with last=1 iff the beat counter is 0.
- RESP:
  - resp_valid=1. resp_rdata, resp_err and resp_last are held stable until resp_ready.
  - On handshake with last=1: go to IDLE.
  - On handshake with last=0: decrement the beat counter; addr = (addr+1) wrapping DM_DEPTH-1 -> 0; go to RD_ADDR.
- Latency from request handshake at edge T:
  - Store: dm_we high in cycle T+1; resp_valid in T+2.
  - Load: first resp_valid in T+3. Each subsequent beat arrives 3 cycles after the previous response handshake.
- Outside WR, dm_we=0. dm_addr and dm_d hold their last value.
- req_ready=0 in every state except IDLE, so one transaction is outstanding at a time. A request arriving during the RESP handshake cycle is accepted only on the next IDLE cycle.
- Back-pressure: resp_ready=0 stalls indefinitely in RESP with no `dm` activity.
- Only the first address is range-checked. Later burst addresses are always in range by wrap.

Test Plan:
- Store 16'd8 to addr 2, then load addr 2, len 0 -> dm_we high for exactly 1 cycle with dm_addr=2, dm_d=8; store ack rdata=0, err=0, last=1; load beat rdata=8, last=1, arriving 3 cycles after acceptance.
- Preload addr 62, 63, 0, 1 with 16'hA, B, C, D; load addr 62, len 3 -> 4 beats A, B, C, D; last only on D; dm_addr sequence 62, 63, 0, 1.
- DM_DEPTH=48: load addr 50, and separately store addr 47 then addr 48 -> addr 50 gives single beat err=1, rdata=0 with no dm_we; addr 47 writes normally; addr 48 gives err=1 and no write.
- Burst len 2 with resp_ready held low 5 cycles on beat 1 -> beat 1 rdata/last stable throughout; dm_addr does not advance; remaining beats are correct afterwards.
- Assert rst during RD_CAP of beat 1 of a 4-beat load -> next cycle all outputs are 0 and req_ready=0; after release req_ready=1, and a new store to addr 5 completes normally.
- req_valid held high back-to-back with stores to addr 3 then 4 -> second request is accepted only after the first ack handshake; dm_we pulses are separated by at least 2 cycles.

Source files
------------

// File: rtl/dm_ctrl.sv
// Initiator-side controller for the data memory: sequences single-word stores and
// 1..4 beat wrapping burst loads, returning one registered response beat per word.
module dm_ctrl #(
    parameter int DATA_WIDTH       = 16,
    parameter int DM_ADDRESS_WIDTH = 6,
    parameter int DM_DEPTH         = 64,
    parameter int LEN_WIDTH        = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [DM_ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]       req_wdata,
    input  logic [LEN_WIDTH-1:0]        req_len,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [DATA_WIDTH-1:0]       resp_rdata,
    output logic                        resp_err,
    output logic                        resp_last,
    output logic                        dm_we,
    output logic [DM_ADDRESS_WIDTH-1:0] dm_addr,
    output logic [DATA_WIDTH-1:0]       dm_d,
    input  logic [DATA_WIDTH-1:0]       dm_q
);

    typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_CAP, RESP} state_t;

    state_t state, next_state;

    logic [DM_ADDRESS_WIDTH-1:0] addr, addr_nx, addr_inc, dm_addr_nx;
    logic [LEN_WIDTH-1:0]        cnt, cnt_nx;
    logic [DATA_WIDTH-1:0]       resp_rdata_nx, dm_d_nx;
    logic                        req_ready_nx, resp_valid_nx, resp_err_nx, resp_last_nx, dm_we_nx;
    logic                        req_hs, resp_hs, addr_bad;

    assign req_hs   = req_valid & req_ready;
    assign resp_hs  = resp_valid & resp_ready;
    assign addr_bad = 32'(req_addr) >= DM_DEPTH;
    assign addr_inc = (addr == DM_ADDRESS_WIDTH'(DM_DEPTH - 1)) ? '0 : addr + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_hs) next_state = addr_bad ? RESP : (req_we ? WR : RD_ADDR);
            WR:      next_state = RESP;
            RD_ADDR: next_state = RD_CAP;
            RD_CAP:  next_state = RESP;
            RESP:    if (resp_hs) next_state = resp_last ? IDLE : RD_ADDR;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered, so their next values are decoded from next_state
    // and the transition being taken.
    always_comb begin
        req_ready_nx  = (next_state == IDLE);
        resp_valid_nx = (next_state == RESP);
        dm_we_nx      = (next_state == WR);
        resp_rdata_nx = resp_rdata;
        resp_err_nx   = resp_err;
        resp_last_nx  = resp_last;
        dm_addr_nx    = dm_addr;
        dm_d_nx       = dm_d;
        addr_nx       = addr;
        cnt_nx        = cnt;
        case (state)
            IDLE: begin
                if (req_hs) begin
                    addr_nx = req_addr;
                    cnt_nx  = req_len;
                    if (addr_bad) begin
                        resp_err_nx   = 1'b1;
                        resp_last_nx  = 1'b1;
                        resp_rdata_nx = '0;
                    end else begin
                        dm_addr_nx = req_addr;
                        if (req_we) dm_d_nx = req_wdata;
                    end
                end
            end
            WR: begin
                resp_err_nx   = 1'b0;
                resp_last_nx  = 1'b1;
                resp_rdata_nx = '0;
            end
            RD_CAP: begin
                resp_err_nx   = 1'b0;
                resp_last_nx  = (cnt == '0);
                resp_rdata_nx = dm_q;
            end
            RESP: begin
                if (resp_hs && !resp_last) begin
                    cnt_nx     = cnt - 1'b1;
                    addr_nx    = addr_inc;
                    dm_addr_nx = addr_inc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_last  <= 1'b0;
            resp_rdata <= '0;
            dm_we      <= 1'b0;
            dm_addr    <= '0;
            dm_d       <= '0;
            addr       <= '0;
            cnt        <= '0;
        end else begin
            req_ready  <= req_ready_nx;
            resp_valid <= resp_valid_nx;
            resp_err   <= resp_err_nx;
            resp_last  <= resp_last_nx;
            resp_rdata <= resp_rdata_nx;
            dm_we      <= dm_we_nx;
            dm_addr    <= dm_addr_nx;
            dm_d       <= dm_d_nx;
            addr       <= addr_nx;
            cnt        <= cnt_nx;
        end
    end

endmodule
